// File: rtl/scroll_controller_pkg.sv
// Shared definitions for the layer-scroll initiator and its row generator.
package scroll_controller_pkg;

  localparam int unsigned LAYER_WIDTH       = 7;
  // Must match the scroll length used by shift_layer.
  localparam int unsigned SCROLL_MS_DEFAULT = 150;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  // Single centre cell used when a generated row would be empty.
  localparam logic [LAYER_WIDTH-1:0] FALLBACK_ROW = 7'b0001000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GEN    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_SETTLE = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  // 16-bit Fibonacci LFSR, taps 15/13/12/10, shifting towards the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

endpackage

// File: rtl/scroll_controller_row_generator.sv
// Combinational next-row generator: advances the LFSR, builds a candidate row,
// forces it to touch the previous row, and masks block types to occupied cells.
module scroll_controller_row_generator
  import scroll_controller_pkg::*;
(
  input  logic [15:0]            i_lfsr,
  input  logic [LAYER_WIDTH-1:0] i_prev_map,
  output logic [15:0]            o_lfsr_next,
  output logic [LAYER_WIDTH-1:0] o_map,
  output logic [LAYER_WIDTH-1:0] o_type
);

  logic [LAYER_WIDTH-1:0] w_mask;
  logic [LAYER_WIDTH-1:0] w_cand;

  // Candidate row with reachability fix-up and empty-row fallback.
  always_comb begin
    o_lfsr_next = lfsr_step(i_lfsr);
    // Cells adjacent to (or on) an occupied previous cell; shifts drop edge bits, no wrap.
    w_mask      = i_prev_map | (i_prev_map << 1) | (i_prev_map >> 1);
    w_cand      = o_lfsr_next[LAYER_WIDTH-1:0];
    if ((w_cand & w_mask) == '0) begin
      w_cand = w_cand | i_prev_map;
    end
    if (w_cand == '0) begin
      w_cand = FALLBACK_ROW;
    end
    o_map  = w_cand;
    o_type = o_lfsr_next[2*LAYER_WIDTH-1:LAYER_WIDTH] & w_cand;
  end

endmodule

// File: rtl/scroll_controller.sv
// Scroll initiator: on request, generates a new top row, strobes load then
// start to the shift layers, times the scroll on one_ms_tick and counts score.
module scroll_controller
  import scroll_controller_pkg::*;
#(
  parameter logic [15:0]            SEED      = LFSR_DEFAULT_SEED,
  parameter logic [LAYER_WIDTH-1:0] INIT_MAP  = 7'b0001000,
  parameter int unsigned            SCROLL_MS = SCROLL_MS_DEFAULT,
  parameter int unsigned            SCORE_MAX = 9999
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   module_en,
  input  logic                   one_ms_tick,
  input  logic                   scroll_req,
  output logic                   load,
  output logic                   start,
  output logic [0:LAYER_WIDTH-1] layer_map_out,
  output logic [0:LAYER_WIDTH-1] block_type_out,
  output logic                   busy,
  output logic                   scroll_done,
  output logic [13:0]            score
);

  localparam logic [15:0]       LFSR_INIT = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;
  localparam int unsigned       CNT_W     = $clog2(SCROLL_MS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCROLL_MS - 1);
  localparam logic [13:0]       SCORE_SAT = 14'(SCORE_MAX);

  state_e                 r_state;
  logic [15:0]            r_lfsr;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_settle;
  logic [LAYER_WIDTH-1:0] r_map;
  logic [LAYER_WIDTH-1:0] r_type;
  logic                   r_load;
  logic                   r_start;
  logic                   r_busy;
  logic                   r_done;
  logic [13:0]            r_score;

  logic [15:0]            w_lfsr_next;
  logic [LAYER_WIDTH-1:0] w_map;
  logic [LAYER_WIDTH-1:0] w_type;

  scroll_controller_row_generator u_row_gen (
    .i_lfsr      (r_lfsr),
    .i_prev_map  (r_map),
    .o_lfsr_next (w_lfsr_next),
    .o_map       (w_map),
    .o_type      (w_type)
  );

  // Scroll sequencer; every output is a flop updated alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_lfsr   <= LFSR_INIT;
      r_cnt    <= '0;
      r_settle <= 1'b0;
      r_map    <= INIT_MAP;
      r_type   <= '0;
      r_load   <= 1'b0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_score  <= '0;
    end else begin
      r_load  <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (scroll_req && module_en) begin
            r_state <= S_GEN;
            r_busy  <= 1'b1;
          end
        end
        S_GEN: begin
          r_lfsr  <= w_lfsr_next;
          r_map   <= w_map;
          r_type  <= w_type;
          r_load  <= 1'b1;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_start <= 1'b1;
          r_state <= S_START;
        end
        S_START: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (one_ms_tick) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt    <= '0;
              r_settle <= 1'b0;
              r_state  <= S_SETTLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          // Two cycles: first marks r_settle, second moves on.
          if (r_settle) begin
            r_settle <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
            if (r_score != SCORE_SAT) begin
              r_score <= r_score + 14'd1;
            end
          end else begin
            r_settle <= 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_cnt    <= '0;
          r_settle <= 1'b0;
        end
      endcase
    end
  end

  assign load           = r_load;
  assign start          = r_start;
  assign layer_map_out  = r_map;
  assign block_type_out = r_type;
  assign busy           = r_busy;
  assign scroll_done    = r_done;
  assign score          = r_score;

endmodule

// File: tb/tb_scroll_controller.sv
// Randomized self-checking bench for scroll_controller with a behavioural row/timing model.
module tb_scroll_controller;

  localparam logic [15:0] SEED      = 16'hACE1;
  localparam logic [6:0]  INIT_MAP  = 7'b0001000;
  localparam int          SCROLL_MS = 150;
  localparam int          SCORE_MAX = 9999;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        module_en;
  logic        one_ms_tick;
  logic        scroll_req;
  logic        load, start, busy, scroll_done;
  logic [6:0]  layer_map_out, block_type_out;
  logic [13:0] score;

  logic        s_req, s_load, s_start, s_busy, s_done;
  logic [6:0]  s_map, s_type;
  logic [13:0] s_score;

  scroll_controller #(
    .SEED      (SEED),
    .INIT_MAP  (INIT_MAP),
    .SCROLL_MS (SCROLL_MS),
    .SCORE_MAX (SCORE_MAX)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .module_en      (module_en),
    .one_ms_tick    (one_ms_tick),
    .scroll_req     (scroll_req),
    .load           (load),
    .start          (start),
    .layer_map_out  (layer_map_out),
    .block_type_out (block_type_out),
    .busy           (busy),
    .scroll_done    (scroll_done),
    .score          (score)
  );

  scroll_controller #(
    .SEED      (SEED),
    .INIT_MAP  (INIT_MAP),
    .SCROLL_MS (4),
    .SCORE_MAX (3)
  ) u_sat (
    .clk            (clk),
    .rst            (rst),
    .module_en      (1'b1),
    .one_ms_tick    (one_ms_tick),
    .scroll_req     (s_req),
    .load           (s_load),
    .start          (s_start),
    .layer_map_out  (s_map),
    .block_type_out (s_type),
    .busy           (s_busy),
    .scroll_done    (s_done),
    .score          (s_score)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tick source: periodic with adjustable period plus one optionally forced tick.
  int tick_per       = 5;
  int tick_force_cyc = -1;
  int tick_at[$];
  initial begin
    int div;
    div = 0;
    one_ms_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (div <= 0) begin
        one_ms_tick = 1'b1;
        div = tick_per - 1;
      end else begin
        one_ms_tick = 1'b0;
        div--;
      end
      if (cyc == tick_force_cyc) one_ms_tick = 1'b1;
      if (one_ms_tick) tick_at.push_back(cyc);
    end
  end

  function automatic int ticks_from(input int from);
    int c;
    c = 0;
    foreach (tick_at[j]) if (tick_at[j] >= from) c++;
    return c;
  endfunction

  function automatic int nth_tick(input int from, input int n);
    int c;
    c = 0;
    foreach (tick_at[j]) begin
      if (tick_at[j] >= from) begin
        c++;
        if (c == n) return tick_at[j];
      end
    end
    return -1;
  endfunction

  // Output event monitors, sampled mid-cycle.
  int          load_cnt = 0, start_cnt = 0, done_cnt = 0, overlap_cnt = 0;
  int          load_cyc = 0, start_cyc = 0, done_cyc = 0;
  logic [6:0]  map_at_load = '0, type_at_load = '0;
  logic [13:0] score_at_done = '0;
  logic        busy_at_done = 1'b0;
  int          s_load_cnt = 0, s_start_cnt = 0, s_done_cnt = 0;
  logic [6:0]  s_map_at_load = '0, s_type_at_load = '0;
  logic [13:0] s_score_at_done = '0;

  always @(negedge clk) begin
    if (load) begin
      load_cnt     <= load_cnt + 1;
      load_cyc     <= cyc;
      map_at_load  <= layer_map_out;
      type_at_load <= block_type_out;
    end
    if (start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (load && start) overlap_cnt <= overlap_cnt + 1;
    if (scroll_done) begin
      done_cnt      <= done_cnt + 1;
      done_cyc      <= cyc;
      score_at_done <= score;
      busy_at_done  <= busy;
    end
    if (s_load) begin
      s_load_cnt     <= s_load_cnt + 1;
      s_map_at_load  <= s_map;
      s_type_at_load <= s_type;
    end
    if (s_start) s_start_cnt <= s_start_cnt + 1;
    if (s_done) begin
      s_done_cnt      <= s_done_cnt + 1;
      s_score_at_done <= s_score;
    end
  end

  // Reference model state.
  logic [15:0] m_lfsr  = SEED;
  logic [6:0]  m_map   = INIT_MAP;
  int          m_score = 0;

  // New row from the rules: reachable means some new cell is within one cell of an old one.
  function automatic void model_row(input logic [15:0] l, input logic [6:0] prev,
                                    output logic [15:0] nl, output logic [6:0] map,
                                    output logic [6:0] typ);
    logic [6:0] cand;
    bit         reach;
    nl    = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    cand  = nl[6:0];
    reach = 1'b0;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        if (cand[i] && prev[j] && (i - j <= 1) && (j - i <= 1)) reach = 1'b1;
      end
    end
    if (!reach) cand = cand | prev;
    if (cand == 7'd0) cand = 7'b0001000;
    map = cand;
    typ = nl[13:7] & cand;
  endfunction

  task automatic do_scroll(input string tag, input bit busy_drop, input bit gate,
                           input bit force_start_tick);
    int          k, n0l, n0s, n0d, nt, t_last, es;
    logic [15:0] nl;
    logic [6:0]  em, et;
    model_row(m_lfsr, m_map, nl, em, et);
    es  = (m_score >= SCORE_MAX) ? SCORE_MAX : m_score + 1;
    n0l = load_cnt;
    n0s = start_cnt;
    n0d = done_cnt;
    tick_per = force_start_tick ? 5 : int'($urandom_range(3, 7));
    repeat ($urandom_range(0, 6)) step();
    tick_at.delete();
    if (gate) begin
      module_en  = 1'b0;
      scroll_req = 1'b1;
      repeat (20) step();
      check_eq({tag, "_gated_no_load"}, load_cnt - n0l, 0);
      module_en = 1'b1;
    end else begin
      scroll_req = 1'b1;
    end
    k = cyc;
    if (force_start_tick) tick_force_cyc = k + 3;
    step();
    scroll_req = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == n0d; i++) begin
      nt = ticks_from(k + 4);
      scroll_req = busy_drop && (nt == 10 || nt == 100);
      if (gate && nt == 5) module_en = 1'b0;
      step();
    end
    scroll_req = 1'b0;
    module_en  = 1'b1;
    t_last = nth_tick(k + 4, SCROLL_MS);
    check_eq({tag, "_done_count"}, done_cnt - n0d, 1);
    check_eq({tag, "_load_count"}, load_cnt - n0l, 1);
    check_eq({tag, "_start_count"}, start_cnt - n0s, 1);
    check_eq({tag, "_load_latency"}, load_cyc - k, 2);
    check_eq({tag, "_start_latency"}, start_cyc - k, 3);
    check_eq({tag, "_map"}, 32'(map_at_load), 32'(em));
    check_eq({tag, "_type"}, 32'(type_at_load), 32'(et));
    check_eq({tag, "_done_cycle"}, done_cyc, t_last + 3);
    check_eq({tag, "_score"}, 32'(score_at_done), es);
    check_eq({tag, "_busy_in_done"}, 32'(busy_at_done), 1);
    check_eq({tag, "_busy_after"}, 32'(busy), 0);
    repeat (3) step();
    check_eq({tag, "_no_extra_load"}, load_cnt - n0l, 1);
    tick_force_cyc = -1;
    m_lfsr  = nl;
    m_map   = em;
    m_score = es;
  endtask

  int k0, l0, s0, d0;

  initial begin
    module_en  = 1'b1;
    scroll_req = 1'b0;
    s_req      = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    check_eq("reset_map", 32'(layer_map_out), 32'(INIT_MAP));
    check_eq("reset_type", 32'(block_type_out), 0);
    check_eq("reset_score", 32'(score), 0);
    check_eq("reset_busy", 32'(busy), 0);
    repeat (10) step();
    check_eq("reset_no_load", load_cnt + start_cnt + done_cnt, 0);

    do_scroll("first", 1'b0, 1'b0, 1'b0);
    check_eq("first_map_const", 32'(map_at_load), 32'(7'b1001011));
    check_eq("first_type_const", 32'(type_at_load), 32'(7'b0000011));
    do_scroll("timing", 1'b0, 1'b0, 1'b1);
    do_scroll("busy_drop", 1'b1, 1'b0, 1'b0);
    do_scroll("gate", 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of the wait phase.
    tick_per = 5;
    tick_at.delete();
    scroll_req = 1'b1;
    k0 = cyc;
    step();
    scroll_req = 1'b0;
    for (int i = 0; i < 1000 && ticks_from(k0 + 4) < 20; i++) step();
    check_eq("rst_mid_busy_before", 32'(busy), 1);
    l0 = load_cnt;
    s0 = start_cnt;
    d0 = done_cnt;
    rst = 1'b0;
    #2;
    check_eq("rst_async_map", 32'(layer_map_out), 32'(INIT_MAP));
    check_eq("rst_async_type", 32'(block_type_out), 0);
    check_eq("rst_async_score", 32'(score), 0);
    check_eq("rst_async_busy", 32'(busy), 0);
    step();
    step();
    rst = 1'b1;
    repeat (10) step();
    check_eq("rst_no_strobes", (load_cnt - l0) + (start_cnt - s0) + (done_cnt - d0), 0);
    check_eq("rst_map_hold", 32'(layer_map_out), 32'(INIT_MAP));
    m_lfsr  = SEED;
    m_map   = INIT_MAP;
    m_score = 0;

    do_scroll("after_rst", 1'b0, 1'b0, 1'b0);
    check_eq("after_rst_map_const", 32'(map_at_load), 32'(7'b1001011));
    for (int r = 0; r < 3; r++) do_scroll($sformatf("rand%0d", r), 1'b0, 1'b0, 1'b0);

    // Saturating score on the small instance.
    for (int n = 1; n <= 5; n++) begin
      d0 = s_done_cnt;
      s_req = 1'b1;
      step();
      s_req = 1'b0;
      for (int i = 0; i < 300 && s_done_cnt == d0; i++) step();
      check_eq($sformatf("sat_done_%0d", n), s_done_cnt - d0, 1);
      check_eq($sformatf("sat_score_%0d", n), 32'(s_score_at_done), (n < 3) ? n : 3);
      check_eq($sformatf("sat_busy_%0d", n), 32'(s_busy), 0);
      step();
    end
    check_eq("sat_load_start", s_load_cnt - s_start_cnt, 0);
    check_eq("sat_map_nonzero", (s_map_at_load != 7'd0) ? 1 : 0, 1);
    check_eq("sat_type_subset", 32'(s_type_at_load & ~s_map_at_load), 0);
    check_eq("no_load_start_overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
